addr_mode_seq: RTL and testbench

Multi-cycle effective-address sequencer for the 6502 core. It sits between the opcode decoder and the memory port. On a start pulse it takes the decoded group-one addressing mode, operand bytes and index registers. It then issues the zero-page pointer and operand reads each mode needs, and returns the 16-bit effective address plus the fetched operand to the datapath. The indirect modes are the multi-cycle cases this block exists to handle.

---
 rtl/addr_mode_seq_if.sv | 29 ++
 rtl/addr_mode_seq.sv | 163 ++++++++++++++++
 tb/tb_addr_mode_seq.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/addr_mode_seq_if.sv
// Decoder/datapath and memory-port signals of the 6502 effective-address sequencer.
// The sequencer takes the slave view; the decoder and memory side take the master view.
interface addr_mode_seq_if;
   logic        start_i;
   logic [2:0]  mode_i;
   logic [15:0] data_i;
   logic [7:0]  x_i;
   logic [7:0]  y_i;
   logic        read_i;
   logic        busy_o;
   logic        done_o;
   logic [15:0] ea_o;
   logic [7:0]  operand_o;
   logic        page_cross_o;
   logic        mem_req_o;
   logic [15:0] mem_addr_o;
   logic        mem_ack_i;
   logic [7:0]  mem_rdata_i;

   modport master (
      output start_i, mode_i, data_i, x_i, y_i, read_i, mem_ack_i, mem_rdata_i,
      input  busy_o, done_o, ea_o, operand_o, page_cross_o, mem_req_o, mem_addr_o
   );

   modport slave (
      input  start_i, mode_i, data_i, x_i, y_i, read_i, mem_ack_i, mem_rdata_i,
      output busy_o, done_o, ea_o, operand_o, page_cross_o, mem_req_o, mem_addr_o
   );
endinterface

// File: rtl/addr_mode_seq.sv
// Multi-cycle effective-address sequencer for the 6502 group-one addressing modes:
// issues zero-page pointer and operand reads and returns EA plus fetched operand.
module addr_mode_seq (
   input logic           clk_i,
   input logic           rstn_i,
   addr_mode_seq_if.slave bus
);
   typedef enum logic [2:0] {IDLE, PTR_LO, PTR_HI, OPERAND, DONE} state_t;

   localparam logic [2:0] M_IND_X = 3'd0;
   localparam logic [2:0] M_ZP    = 3'd1;
   localparam logic [2:0] M_IMM   = 3'd2;
   localparam logic [2:0] M_ABS   = 3'd3;
   localparam logic [2:0] M_IND_Y = 3'd4;
   localparam logic [2:0] M_ZP_X  = 3'd5;
   localparam logic [2:0] M_ABS_Y = 3'd6;
   localparam logic [2:0] M_ABS_X = 3'd7;

   state_t      state, state_nxt;
   logic [2:0]  mode_r;
   logic [7:0]  y_r;
   logic        read_r;
   logic [7:0]  ptr_lo_r;
   logic        req_nxt;
   logic [15:0] addr_nxt;

   // EA of every mode that needs no pointer read; bit 16 is the page-cross flag.
   function automatic logic [16:0] direct_ea(input logic [2:0] mode, input logic [15:0] data,
                                             input logic [7:0] x, input logic [7:0] y);
      logic [15:0] ea;
      logic        pc;
      ea = 16'h0000;
      pc = 1'b0;
      case (mode)
         M_ZP:    ea = {8'h00, data[7:0]};
         M_ZP_X:  ea = {8'h00, data[7:0] + x};
         M_ABS:   ea = data;
         M_ABS_Y: begin
            ea = data + {8'h00, y};
            pc = (ea[15:8] != data[15:8]);
         end
         M_ABS_X: begin
            ea = data + {8'h00, x};
            pc = (ea[15:8] != data[15:8]);
         end
         default: ;
      endcase
      return {pc, ea};
   endfunction

   logic [16:0] dir_res;
   logic [7:0]  zp_ptr;
   logic        is_ind;
   logic        accept;
   logic        ack;
   logic [15:0] ptr_base;
   logic [15:0] ind_ea;
   logic        ind_pc;

   assign dir_res  = direct_ea(bus.mode_i, bus.data_i, bus.x_i, bus.y_i);
   assign is_ind   = (bus.mode_i == M_IND_X) || (bus.mode_i == M_IND_Y);
   assign zp_ptr   = (bus.mode_i == M_IND_X) ? bus.data_i[7:0] + bus.x_i : bus.data_i[7:0];
   assign accept   = (state == IDLE) && bus.start_i;
   assign ack      = bus.mem_req_o && bus.mem_ack_i;
   // High pointer byte arrives on the bus in the same cycle the EA is formed.
   assign ptr_base = {bus.mem_rdata_i, ptr_lo_r};
   assign ind_ea   = (mode_r == M_IND_Y) ? ptr_base + {8'h00, y_r} : ptr_base;
   assign ind_pc   = (mode_r == M_IND_Y) && (ind_ea[15:8] != bus.mem_rdata_i);

   assign bus.busy_o = (state != IDLE);
   assign bus.done_o = (state == DONE);

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         state          <= IDLE;
         bus.mem_req_o  <= 1'b0;
         bus.mem_addr_o <= 16'h0000;
      end else begin
         state          <= state_nxt;
         bus.mem_req_o  <= req_nxt;
         bus.mem_addr_o <= addr_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      req_nxt   = bus.mem_req_o;
      addr_nxt  = bus.mem_addr_o;
      case (state)
         IDLE: begin
            if (bus.start_i) begin
               if (bus.mode_i == M_IMM) begin
                  state_nxt = DONE;
               end else if (is_ind) begin
                  state_nxt = PTR_LO;
                  req_nxt   = 1'b1;
                  addr_nxt  = {8'h00, zp_ptr};
               end else if (bus.read_i) begin
                  state_nxt = OPERAND;
                  req_nxt   = 1'b1;
                  addr_nxt  = dir_res[15:0];
               end else begin
                  state_nxt = DONE;
               end
            end
         end
         PTR_LO: begin
            if (ack) begin
               state_nxt = PTR_HI;
               addr_nxt  = {8'h00, bus.mem_addr_o[7:0] + 8'h01};
            end
         end
         PTR_HI: begin
            if (ack) begin
               if (read_r) begin
                  state_nxt = OPERAND;
                  addr_nxt  = ind_ea;
               end else begin
                  state_nxt = DONE;
                  req_nxt   = 1'b0;
               end
            end
         end
         OPERAND: begin
            if (ack) begin
               state_nxt = DONE;
               req_nxt   = 1'b0;
            end
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         mode_r           <= 3'd0;
         y_r              <= 8'h00;
         read_r           <= 1'b0;
         ptr_lo_r         <= 8'h00;
         bus.ea_o         <= 16'h0000;
         bus.operand_o    <= 8'h00;
         bus.page_cross_o <= 1'b0;
      end else begin
         if (accept) begin
            mode_r        <= bus.mode_i;
            y_r           <= bus.y_i;
            read_r        <= bus.read_i;
            bus.operand_o <= (bus.mode_i == M_IMM) ? bus.data_i[7:0] : 8'h00;
            if (!is_ind) begin
               bus.ea_o         <= dir_res[15:0];
               bus.page_cross_o <= dir_res[16];
            end
         end
         if (state == PTR_LO && ack) ptr_lo_r <= bus.mem_rdata_i;
         if (state == PTR_HI && ack) begin
            bus.ea_o         <= ind_ea;
            bus.page_cross_o <= ind_pc;
         end
         if (state == OPERAND && ack) bus.operand_o <= bus.mem_rdata_i;
      end
   end
endmodule

// File: tb/tb_addr_mode_seq.sv
// Randomised self-checking bench for addr_mode_seq: a wait-state memory responder
// plus an arithmetic reference model of the addressing-mode rules.
module tb_addr_mode_seq;
   logic clk = 1'b0;
   logic rstn;
   always #5 clk = ~clk;

   addr_mode_seq_if bus();
   addr_mode_seq dut (.clk_i(clk), .rstn_i(rstn), .bus(bus));

   logic [7:0] mem [0:65535];
   int checks = 0;
   int errors = 0;
   int wait_fixed = 0;
   bit spurious = 1'b0;
   int rd_log[$];
   int wait_log[$];
   int exp_rd[$];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Memory responder: logs each new request, inserts wait states, verifies address hold.
   bit new_req = 1'b1;
   int cnt = 0;
   int target = 0;
   logic [15:0] hold_addr = 16'h0000;
   always @(negedge clk) begin
      bus.mem_ack_i = 1'b0;
      if (bus.mem_req_o === 1'b1) begin
         if (new_req) begin
            new_req   = 1'b0;
            cnt       = 0;
            hold_addr = bus.mem_addr_o;
            rd_log.push_back(int'(bus.mem_addr_o));
            target = (wait_fixed < 0) ? int'($urandom_range(0, 2)) : wait_fixed;
            wait_log.push_back(target);
         end else begin
            chk("addr_stable", bus.mem_addr_o, hold_addr);
         end
         if (cnt == target) begin
            bus.mem_ack_i   = 1'b1;
            bus.mem_rdata_i = mem[bus.mem_addr_o];
            new_req         = 1'b1;
         end else begin
            cnt++;
            bus.mem_rdata_i = 8'($urandom);
         end
      end else begin
         new_req = 1'b1;
         if (spurious) begin
            bus.mem_ack_i   = 1'($urandom);
            bus.mem_rdata_i = 8'($urandom);
         end
      end
   end

   task automatic model(input int mode, input int data, input int x, input int y, input bit rd,
                        output int ea, output int op, output int pc);
      int lo, p, base;
      lo = data % 256;
      ea = 0; op = 0; pc = 0;
      exp_rd.delete();
      case (mode)
         0: begin
            p = (lo + x) % 256;
            exp_rd.push_back(p);
            exp_rd.push_back((p + 1) % 256);
            ea = int'(mem[(p + 1) % 256]) * 256 + int'(mem[p]);
         end
         1: ea = lo;
         2: op = lo;
         3: ea = data;
         4: begin
            exp_rd.push_back(lo);
            exp_rd.push_back((lo + 1) % 256);
            base = int'(mem[(lo + 1) % 256]) * 256 + int'(mem[lo]);
            ea = (base + y) % 65536;
            pc = (ea / 256 != base / 256) ? 1 : 0;
         end
         5: ea = (lo + x) % 256;
         6: begin ea = (data + y) % 65536; pc = (ea / 256 != data / 256) ? 1 : 0; end
         default: begin ea = (data + x) % 65536; pc = (ea / 256 != data / 256) ? 1 : 0; end
      endcase
      if (mode != 2 && rd) begin
         exp_rd.push_back(ea);
         op = int'(mem[ea]);
      end
   endtask

   task automatic drive(input int mode, input int data, input int x, input int y, input bit rd);
      bus.mode_i  = 3'(mode);
      bus.data_i  = 16'(data);
      bus.x_i     = 8'(x);
      bus.y_i     = 8'(y);
      bus.read_i  = rd;
      bus.start_i = 1'b1;
   endtask

   task automatic wait_done(input string tag, inout int n);
      while (!bus.done_o && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk({tag, ":done_seen"}, bus.done_o, 1'b1);
   endtask

   task automatic check_result(input string tag, input int ea, input int op, input int pc);
      chk({tag, ":ea"}, bus.ea_o, ea);
      chk({tag, ":operand"}, bus.operand_o, op);
      chk({tag, ":page_cross"}, bus.page_cross_o, pc);
   endtask

   task automatic check_reads(input string tag);
      chk({tag, ":nreads"}, rd_log.size(), exp_rd.size());
      for (int i = 0; i < rd_log.size() && i < exp_rd.size(); i++)
         chk({tag, ":read_addr"}, rd_log[i], exp_rd[i]);
   endtask

   task automatic run_txn(input string tag, input int mode, input int data, input int x,
                          input int y, input bit rd, input int exp_lat);
      int ea, op, pc, n, lat;
      model(mode, data, x, y, rd, ea, op, pc);
      for (int k = 0; k < 50 && bus.busy_o; k++) @(negedge clk);
      rd_log.delete();
      wait_log.delete();
      drive(mode, data, x, y, rd);
      @(negedge clk);
      bus.start_i = 1'b0;
      n = 1;
      wait_done(tag, n);
      lat = 1;
      foreach (wait_log[i]) lat += 1 + wait_log[i];
      chk({tag, ":latency"}, n, (exp_lat >= 0) ? exp_lat : lat);
      check_result(tag, ea, op, pc);
      chk({tag, ":busy_in_done"}, bus.busy_o, 1'b1);
      chk({tag, ":req_in_done"}, bus.mem_req_o, 1'b0);
      check_reads(tag);
      @(negedge clk);
      chk({tag, ":done_pulse"}, bus.done_o, 1'b0);
      chk({tag, ":idle_after"}, bus.busy_o, 1'b0);
   endtask

   initial begin
      int ea, op, pc, n;
      rstn = 1'b0;
      bus.start_i = 1'b0; bus.mode_i = 3'd0; bus.data_i = 16'h0; bus.x_i = 8'h0;
      bus.y_i = 8'h0; bus.read_i = 1'b0;
      for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
      repeat (3) @(negedge clk);
      chk("rst:busy", bus.busy_o, 1'b0);
      chk("rst:done", bus.done_o, 1'b0);
      chk("rst:req", bus.mem_req_o, 1'b0);
      chk("rst:addr", bus.mem_addr_o, 16'h0);
      chk("rst:ea", bus.ea_o, 16'h0);
      chk("rst:operand", bus.operand_o, 8'h0);
      chk("rst:page_cross", bus.page_cross_o, 1'b0);
      rstn = 1'b1;
      @(negedge clk);

      wait_fixed = 0;
      run_txn("imm", 2, 'h0042, 'h11, 'h22, 1, 1);
      mem['h0010] = 8'h5A;
      run_txn("zpx_wrap", 5, 'h00F0, 'h20, 0, 1, 2);
      wait_fixed = 2;
      run_txn("absy_cross", 6, 'h12FF, 0, 'h01, 1, 4);
      wait_fixed = 0;
      mem['h00FF] = 8'h34; mem['h0000] = 8'h12; mem['h1244] = 8'h77;
      run_txn("indy_wrap", 4, 'h00FF, 0, 'h10, 1, 4);
      mem['h0085] = 8'h00; mem['h0086] = 8'h20;
      run_txn("indx_noread", 0, 'h0080, 'h05, 0, 0, 3);
      run_txn("abs_noread", 3, 'hBEEF, 0, 0, 0, 1);
      run_txn("indy_cross", 4, 'h0040, 0, 'hFF, 1, -1);

      // start held high through an IND1_X sequence
      model(0, 'h0080, 'h05, 0, 0, ea, op, pc);
      rd_log.delete(); wait_log.delete();
      drive(0, 'h0080, 'h05, 0, 0);
      @(negedge clk);
      n = 1;
      wait_done("hold1", n);
      chk("hold1:latency", n, 3);
      check_result("hold1", ea, op, pc);
      @(negedge clk);
      chk("hold:idle_gap", bus.busy_o, 1'b0);
      chk("hold:no_done", bus.done_o, 1'b0);
      chk("hold:nreads_first", rd_log.size(), 2);
      @(negedge clk);
      chk("hold:second_accepted", bus.busy_o, 1'b1);
      bus.start_i = 1'b0;
      n = 2;
      wait_done("hold2", n);
      check_result("hold2", ea, op, pc);
      chk("hold:nreads_total", rd_log.size(), 4);
      @(negedge clk);

      // asynchronous reset during PTR_HI
      rd_log.delete(); wait_log.delete();
      drive(0, 'h0040, 'h03, 0, 1);
      @(negedge clk);
      bus.start_i = 1'b0;
      @(negedge clk);
      chk("rstmid:busy_before", bus.busy_o, 1'b1);
      chk("rstmid:req_before", bus.mem_req_o, 1'b1);
      chk("rstmid:addr_before", bus.mem_addr_o, 16'h0044);
      #2 rstn = 1'b0;
      #1;
      chk("rstmid:busy", bus.busy_o, 1'b0);
      chk("rstmid:req", bus.mem_req_o, 1'b0);
      chk("rstmid:addr", bus.mem_addr_o, 16'h0);
      chk("rstmid:ea", bus.ea_o, 16'h0);
      chk("rstmid:done", bus.done_o, 1'b0);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("rstmid:no_done", bus.done_o, 1'b0);
      end
      rstn = 1'b1;
      @(negedge clk);
      chk("rstmid:no_done_after", bus.done_o, 1'b0);
      run_txn("after_rst", 0, 'h0040, 'h03, 0, 1, 4);

      // randomised phase with wait states and acks outside requests
      wait_fixed = -1;
      spurious = 1'b1;
      for (int t = 0; t < 60; t++)
         run_txn("rand", int'($urandom_range(0, 7)), int'($urandom_range(0, 65535)),
                 int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                 1'($urandom), -1);
      spurious = 1'b0;
      @(negedge clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
